// File: rtl/wave_pkg.sv
// rtl/wave_pkg.sv - shared types, widths and sample conversion for the waveform capture/display path
package wave_pkg;

    localparam int WAVE_ADDR_W   = 9;
    localparam int WAVE_IDX_W    = 8;
    localparam int WAVE_SAMPLE_W = 8;

    // Capture state encoding, kept as plain constants for older consumers.
    typedef logic [1:0] wave_state_t;
    localparam wave_state_t ST_ARMED  = 2'd0;
    localparam wave_state_t ST_ACTIVE = 2'd1;
    localparam wave_state_t ST_WAIT   = 2'd2;

    // Signed 16-bit sample to 8-bit offset-binary: flipping the sign bit
    // maps -32768..32767 onto 0..255 using the top byte.
    function automatic logic [WAVE_SAMPLE_W-1:0] to_wave_u8(input logic [15:0] s);
        return {~s[15], s[14:8]};
    endfunction

endpackage

// File: rtl/wave_trigger.sv
// rtl/wave_trigger.sv - positive zero-crossing detector with optional armed timeout (TRIGGER_TIMEOUT_EN)
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   strobe          new sample valid this cycle
//   sample_sign     sign bit of the new sample
//   armed           capture FSM is waiting for a trigger
//   trigger         single-cycle trigger pulse, only while armed
module wave_trigger #(
    parameter int TIMEOUT_SAMPLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic strobe,
    input  logic sample_sign,
    input  logic armed,
    output logic trigger
);

    // Only the sign of the previous sample takes part in crossing detection,
    // so that is all that is kept. Updated on every strobe in every state.
    logic prev_neg;
    logic crossing;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_neg <= 1'b0;
        end else if (strobe) begin
            prev_neg <= sample_sign;
        end
    end

    // Negative -> non-negative; zero counts as non-negative.
    assign crossing = strobe & prev_neg & ~sample_sign;

`ifdef TRIGGER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_SAMPLES + 1);

    logic [CNT_W-1:0] armed_cnt;
    logic             timeout;

    // Fires on the TIMEOUT_SAMPLES-th strobe seen while armed.
    assign timeout = strobe & (armed_cnt == CNT_W'(TIMEOUT_SAMPLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed_cnt <= '0;
        end else if (!armed) begin
            armed_cnt <= '0;
        end else if (strobe) begin
            armed_cnt <= (crossing | timeout) ? '0 : armed_cnt + CNT_W'(1);
        end
    end

    assign trigger = armed & (crossing | timeout);
`else
    localparam int unused_timeout_samples = TIMEOUT_SAMPLES;

    assign trigger = armed & crossing;
`endif

endmodule

// File: rtl/wave_capture.sv
// rtl/wave_capture.sv - triggered 256-sample capture into the hidden half of the waveform display RAM
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   new_sample_ready    one-cycle strobe qualifying new_sample_in
//   new_sample_in       signed 16-bit audio sample
//   wave_display_idle   display is not scanning; safe to swap halves
//   write_address       RAM write address {~read_index, index}
//   write_enable        one-cycle RAM write strobe
//   write_sample        offset-binary 8-bit sample
//   read_index          half shown by the display
// Optional build macro: TRIGGER_TIMEOUT_EN (forced trigger after TIMEOUT_SAMPLES armed strobes).
module wave_capture
    import wave_pkg::*;
#(
    parameter int DECIMATE        = 1,     // 1..16
    parameter int TIMEOUT_SAMPLES = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     new_sample_ready,
    input  logic [15:0]              new_sample_in,
    input  logic                     wave_display_idle,
    output logic [WAVE_ADDR_W-1:0]   write_address,
    output logic                     write_enable,
    output logic [WAVE_SAMPLE_W-1:0] write_sample,
    output logic                     read_index
);

    wave_state_t           state;
    logic [WAVE_IDX_W-1:0] index;
    logic [3:0]            dec_cnt;
    logic                  trigger;
    logic                  dec_last;
    logic                  unused_low_bits;

    // Only the top byte of a sample is stored.
    assign unused_low_bits = ^new_sample_in[7:0];

    wave_trigger #(
        .TIMEOUT_SAMPLES(TIMEOUT_SAMPLES)
    ) u_trigger (
        .clk        (clk),
        .reset      (reset),
        .strobe     (new_sample_ready),
        .sample_sign(new_sample_in[15]),
        .armed      (state == ST_ARMED),
        .trigger    (trigger)
    );

    assign dec_last = (dec_cnt == 4'(DECIMATE - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_ARMED;
            index         <= '0;
            dec_cnt       <= '0;
            read_index    <= 1'b0;
            write_enable  <= 1'b0;
            write_address <= '0;
            write_sample  <= '0;
        end else begin
            write_enable <= 1'b0;
            case (state)
                ST_ARMED: begin
                    // The triggering sample itself is stored at index 0.
                    if (trigger) begin
                        write_enable  <= 1'b1;
                        write_address <= {~read_index, {WAVE_IDX_W{1'b0}}};
                        write_sample  <= to_wave_u8(new_sample_in);
                        index         <= WAVE_IDX_W'(1);
                        dec_cnt       <= '0;
                        state         <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (new_sample_ready) begin
                        if (dec_last) begin
                            dec_cnt       <= '0;
                            write_enable  <= 1'b1;
                            write_address <= {~read_index, index};
                            write_sample  <= to_wave_u8(new_sample_in);
                            index         <= index + WAVE_IDX_W'(1);
                            if (index == {WAVE_IDX_W{1'b1}}) begin
                                state <= ST_WAIT;
                            end
                        end else begin
                            dec_cnt <= dec_cnt + 4'd1;
                        end
                    end
                end
                ST_WAIT: begin
                    // Swap only while the display is idle so it never sees a torn half.
                    if (wave_display_idle) begin
                        read_index <= ~read_index;
                        state      <= ST_ARMED;
                    end
                end
                default: state <= ST_ARMED;
            endcase
        end
    end

endmodule

// File: tb/tb_wave_capture.sv
// tb/tb_wave_capture.sv - self-checking bench for wave_capture (DECIMATE 1 and 4 instances)
module tb_wave_capture;

    localparam int TMO = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        new_sample_ready;
    logic [15:0] new_sample_in;
    logic        wave_display_idle;

    logic [8:0]  wa0, wa1;
    logic        we0, we1;
    logic [7:0]  ws0, ws1;
    logic        ri0, ri1;

    always #5 clk = ~clk;

    wave_capture #(.DECIMATE(1), .TIMEOUT_SAMPLES(TMO)) dut (
        .clk(clk), .reset(reset), .new_sample_ready(new_sample_ready),
        .new_sample_in(new_sample_in), .wave_display_idle(wave_display_idle),
        .write_address(wa0), .write_enable(we0), .write_sample(ws0), .read_index(ri0)
    );

    wave_capture #(.DECIMATE(4), .TIMEOUT_SAMPLES(TMO)) dut4 (
        .clk(clk), .reset(reset), .new_sample_ready(new_sample_ready),
        .new_sample_in(new_sample_in), .wave_display_idle(wave_display_idle),
        .write_address(wa1), .write_enable(we1), .write_sample(ws1), .read_index(ri1)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 armed, 1 capturing, 2 waiting for display idle.
    int m_mode[2], m_k[2], m_w[2], m_arm[2];
    bit m_prevneg[2], m_half[2];

    int n_wr[2];
    int first_wr_strobe[2];
    int first_wr_addr[2];
    int strobe_no;
    int wr4[$];

    function automatic int dec_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = 0; m_k[d] = 0; m_w[d] = 0; m_arm[d] = 0;
            m_prevneg[d] = 1'b0; m_half[d] = 1'b0;
            n_wr[d] = 0; first_wr_strobe[d] = -1; first_wr_addr[d] = -1;
        end
        strobe_no = 0;
        wr4.delete();
    endtask

    task automatic model_step(input int d, input bit stb, input logic [15:0] s, input bit idle,
                              output bit we, output int addr, output int data);
        int sv;
        bit fire;
        sv   = int'($signed(s));
        we   = 1'b0;
        addr = 0;
        data = (sv + 32768) / 256;
        fire = 1'b0;
        case (m_mode[d])
            0: if (stb) begin
                m_arm[d]++;
                fire = m_prevneg[d] && (sv >= 0);
`ifdef TRIGGER_TIMEOUT_EN
                if (m_arm[d] == TMO) fire = 1'b1;
`endif
                if (fire) begin
                    we = 1'b1; addr = m_half[d] ? 0 : 256;
                    m_w[d] = 1; m_k[d] = 0; m_mode[d] = 1;
                end
            end
            1: if (stb) begin
                m_k[d]++;
                if (m_k[d] % dec_of(d) == 0) begin
                    we = 1'b1; addr = (m_half[d] ? 0 : 256) + m_w[d];
                    m_w[d]++;
                    if (m_w[d] == 256) m_mode[d] = 2;
                end
            end
            default: if (idle) begin
                m_half[d] = ~m_half[d]; m_mode[d] = 0; m_arm[d] = 0;
            end
        endcase
        if (stb) m_prevneg[d] = (sv < 0);
    endtask

    task automatic step(input bit stb, input logic [15:0] s, input bit idle);
        bit ewe[2];
        int ea[2], ed[2];
        int aw, aa, ad, ar;
        new_sample_ready  = stb;
        new_sample_in     = s;
        wave_display_idle = idle;
        for (int d = 0; d < 2; d++) model_step(d, stb, s, idle, ewe[d], ea[d], ed[d]);
        if (stb) strobe_no++;
        @(posedge clk);
        #1;
        new_sample_ready = 1'b0;
        for (int d = 0; d < 2; d++) begin
            aw = (d == 0) ? int'(we0) : int'(we1);
            aa = (d == 0) ? int'(wa0) : int'(wa1);
            ad = (d == 0) ? int'(ws0) : int'(ws1);
            ar = (d == 0) ? int'(ri0) : int'(ri1);
            chk($sformatf("model_we[%0d]", d), aw, int'(ewe[d]));
            chk($sformatf("model_read_index[%0d]", d), ar, int'(m_half[d]));
            if (ewe[d]) begin
                chk($sformatf("model_addr[%0d]", d), aa, ea[d]);
                chk($sformatf("model_data[%0d]", d), ad, ed[d]);
            end
            if (aw != 0) begin
                n_wr[d]++;
                if (first_wr_strobe[d] < 0) begin
                    first_wr_strobe[d] = strobe_no;
                    first_wr_addr[d]   = aa;
                end
                if (d == 1) wr4.push_back(strobe_no);
            end
        end
    endtask

    task automatic strobe_gap(input logic [15:0] s, input bit idle);
        step(1'b1, s, idle);
        step(1'b0, 16'h0, idle);
    endtask

    function automatic logic [15:0] rnd_sample();
        if ($urandom_range(0, 7) == 0) return 16'($urandom());
        return 16'(int'($urandom_range(0, 400)) - 200);
    endfunction

    typedef struct {
        logic [15:0] s;
        bit          we;
        logic [8:0]  addr;
        logic [7:0]  data;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{16'hFF9C, 1'b0, 9'h000, 8'h00};   // -100: arms prev, no write
        tbl[1] = '{16'h0032, 1'b1, 9'h100, 8'h80};   // +50: crossing
        tbl[2] = '{16'h8000, 1'b1, 9'h101, 8'h00};   // -32768
        tbl[3] = '{16'h7FFF, 1'b1, 9'h102, 8'hFF};   // +32767
        tbl[4] = '{16'hFF00, 1'b1, 9'h103, 8'h7F};   // -256
        tbl[5] = '{16'h0100, 1'b1, 9'h104, 8'h81};   // +256

        reset = 1'b0; new_sample_ready = 1'b0; new_sample_in = '0; wave_display_idle = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_we0", int'(we0), 0);
        chk("reset_we1", int'(we1), 0);
        chk("reset_addr0", int'(wa0), 0);
        chk("reset_data0", int'(ws0), 0);
        chk("reset_ri0", int'(ri0), 0);
        chk("reset_ri1", int'(ri1), 0);
        reset = 1'b1;

        // Table-driven first capture with boundary values.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, tbl[i].s, 1'b0);
            chk($sformatf("tbl_we[%0d]", i), int'(we0), int'(tbl[i].we));
            if (tbl[i].we) begin
                chk($sformatf("tbl_addr[%0d]", i), int'(wa0), int'(tbl[i].addr));
                chk($sformatf("tbl_data[%0d]", i), int'(ws0), int'(tbl[i].data));
            end
            step(1'b0, 16'h0, 1'b0);
        end
        repeat (251) strobe_gap(rnd_sample(), 1'b0);
        chk("cap1_writes", n_wr[0], 256);

        // Keep feeding until the DECIMATE=4 capture completes (trigger was strobe 2).
        while (strobe_no < 1022) strobe_gap(rnd_sample(), 1'b0);
        chk("dec4_writes", n_wr[1], 256);
        chk("dec4_second_gap", wr4[1] - wr4[0], 4);
        chk("dec4_last_gap", wr4[255] - wr4[0], 1020);
        chk("cap1_no_write_in_wait", n_wr[0], 256);

        repeat (1000) step(1'b0, 16'h0, 1'b0);
        chk("wait_ri0_hold", int'(ri0), 0);
        chk("wait_ri1_hold", int'(ri1), 0);
        chk("wait_no_writes", n_wr[0], 256);

        step(1'b0, 16'h0, 1'b1);
        chk("flip_ri0", int'(ri0), 1);
        step(1'b0, 16'h0, 1'b0);

        // Second capture into the lower half; zero after a negative triggers.
        strobe_gap(16'hFFFB, 1'b0);
        step(1'b1, 16'h0000, 1'b0);
        chk("zero_trig_we", int'(we0), 1);
        chk("zero_trig_addr", int'(wa0), 9'h000);
        chk("zero_trig_data", int'(ws0), 8'h80);
        step(1'b0, 16'h0, 1'b0);
        repeat (100) strobe_gap(rnd_sample(), 1'b0);
        step(1'b1, 16'h1234, 1'b0);
        chk("pre_reset_we", int'(we0), 1);

        // Asynchronous reset mid-capture.
        #1 reset = 1'b0;
        #1;
        chk("async_reset_we0", int'(we0), 0);
        chk("async_reset_ri0", int'(ri0), 0);
        chk("async_reset_ri1", int'(ri1), 0);
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        strobe_gap(16'd10, 1'b0);
        strobe_gap(16'd20, 1'b0);
        strobe_gap(16'hFFFF, 1'b0);
        chk("no_write_before_crossing", n_wr[0], 0);
        step(1'b1, 16'd1, 1'b0);
        chk("post_reset_trig_addr", int'(wa0), 9'h100);
        chk("post_reset_trig_data", int'(ws0), 8'h80);
        step(1'b0, 16'h0, 1'b0);

        // Randomised traffic with random display idle and gaps.
        for (int i = 0; i < 2000; i++) begin
            step(1'b1, rnd_sample(), $urandom_range(0, 9) == 0);
            repeat ($urandom_range(1, 3)) step(1'b0, 16'h0, $urandom_range(0, 9) == 0);
        end

        // Constant DC input.
        reset = 1'b0;
        model_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (5000) strobe_gap(16'd1000, 1'b0);
`ifdef TRIGGER_TIMEOUT_EN
        chk("timeout_first_strobe0", first_wr_strobe[0], TMO);
        chk("timeout_first_addr0", first_wr_addr[0], 9'h100);
        chk("timeout_first_strobe1", first_wr_strobe[1], TMO);
`else
        chk("dc_no_writes0", n_wr[0], 0);
        chk("dc_no_writes1", n_wr[1], 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
